// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Owns the single register-file write port. The in-order pipeline writeback
// always has priority; results from the long-latency unit (mul/div, late
// loads) are queued in a small in-order FIFO and drained whenever the main
// path is idle. A busy scoreboard tracks destinations with an outstanding
// long-latency result so decode can stall on RAW/WAW hazards.
//
// Optional feature macro: WB_LU_BYPASS_EN
//   defined   -> a long-unit result is written straight through (zero cycles)
//                when the FIFO is empty and the main path is idle.
//   undefined -> every accepted long-unit result goes through the FIFO, so
//                there is no combinational path from lu_* to rd_*.
//
// Parameters:
//   XLEN        data width
//   FIFO_DEPTH  long-unit result FIFO entries (power of two, >= 2)
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   main_wren_i/addr_i/data_i   pipeline writeback (never backpressured)
//   lu_valid_i/ready_o          long-unit result handshake
//   lu_addr_i/data_i            long-unit result destination and data
//   iss_valid_i/iss_addr_i      long op issued; marks its destination busy
//   rs1/rs2/dst_addr_i          decode-stage hazard query
//   hazard_o                    any queried register is busy
//   rd_wren_o/addr_o/data_o     register-file write port
//   fifo_count_o                current FIFO occupancy
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            main_wren_i,
    input  logic [4:0]                      main_addr_i,
    input  logic [XLEN-1:0]                 main_data_i,
    input  logic                            lu_valid_i,
    output logic                            lu_ready_o,
    input  logic [4:0]                      lu_addr_i,
    input  logic [XLEN-1:0]                 lu_data_i,
    input  logic                            iss_valid_i,
    input  logic [4:0]                      iss_addr_i,
    input  logic [4:0]                      rs1_addr_i,
    input  logic [4:0]                      rs2_addr_i,
    input  logic [4:0]                      dst_addr_i,
    output logic                            hazard_o,
    output logic                            rd_wren_o,
    output logic [4:0]                      rd_addr_o,
    output logic [XLEN-1:0]                 rd_data_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // FIFO state
    logic [4:0]      addr_mem [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;

    // Scoreboard state
    logic [31:0]     busy_reg, busy_next;

    // Arbitration decisions
    logic            main_sel;
    logic            fifo_empty;
    logic            lu_accept;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            clr_valid;
    logic [4:0]      clr_addr;
    logic [4:0]      head_addr;
    logic [XLEN-1:0] head_data;

    logic            wren_int;
    logic [4:0]      addr_int;
    logic [XLEN-1:0] data_int;

    assign head_addr  = addr_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];
    assign fifo_empty = (count_reg == '0);

    // Ready looks only at the registered count: a pop in the same cycle
    // does not open a slot until the next cycle.
    assign lu_ready_o = (count_reg < DEPTH_C);
    assign lu_accept  = lu_valid_i && lu_ready_o;

    // A main write to x0 is treated as idle so the FIFO can drain.
    assign main_sel   = main_wren_i && (main_addr_i != 5'd0);
    assign pop        = !main_sel && !fifo_empty;

`ifdef WB_LU_BYPASS_EN
    assign bypass     = !main_sel && fifo_empty && lu_accept && (lu_addr_i != 5'd0);
`else
    assign bypass     = 1'b0;
`endif

    // Address-0 results complete the handshake but are dropped.
    assign push       = lu_accept && (lu_addr_i != 5'd0) && !bypass;

    assign clr_valid  = pop || bypass;
    assign clr_addr   = pop ? head_addr : lu_addr_i;

    // Write-port priority: main path, FIFO head, bypass, idle.
    always_comb begin
        wren_int = 1'b0;
        addr_int = 5'd0;
        data_int = '0;
        if (main_sel) begin
            wren_int = 1'b1;
            addr_int = main_addr_i;
            data_int = main_data_i;
        end else if (pop) begin
            wren_int = 1'b1;
            addr_int = head_addr;
            data_int = head_data;
        end else if (bypass) begin
            wren_int = 1'b1;
            addr_int = lu_addr_i;
            data_int = lu_data_i;
        end
    end

    // Gate with reset so the write port goes quiet immediately on assertion,
    // even though the main path is purely combinational.
    assign rd_wren_o = rst_ni && wren_int;
    assign rd_addr_o = rst_ni ? addr_int : 5'd0;
    assign rd_data_o = rst_ni ? data_int : '0;

    assign fifo_count_o = count_reg;

    // Pointer and count update
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            busy_reg   <= busy_next;
        end
    end

    // FIFO storage, one register slot per entry
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    addr_mem[gi] <= 5'd0;
                    data_mem[gi] <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    addr_mem[gi] <= lu_addr_i;
                    data_mem[gi] <= lu_data_i;
                end
            end
        end
    endgenerate

    // Scoreboard: a new issue to the same register outranks the retiring
    // write, since the register has a fresh outstanding result.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                logic set_hit;
                logic clr_hit;
                assign set_hit = iss_valid_i && (iss_addr_i == 5'(gi));
                assign clr_hit = clr_valid && (clr_addr == 5'(gi));
                assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
            end
        end
    endgenerate

    assign hazard_o = busy_reg[rs1_addr_i] | busy_reg[rs2_addr_i] | busy_reg[dst_addr_i];

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Self-checking bench for wb_arbiter. A queue-based reference model derives
// the expected write port, readiness, occupancy and hazard each cycle from
// the arbitration rules; directed scenarios are followed by a randomized run.
// Builds with or without WB_LU_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_LU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            main_wren;
    logic [4:0]      main_addr;
    logic [XLEN-1:0] main_data;
    logic            lu_valid;
    logic            lu_ready;
    logic [4:0]      lu_addr;
    logic [XLEN-1:0] lu_data;
    logic            iss_valid;
    logic [4:0]      iss_addr;
    logic [4:0]      rs1_addr, rs2_addr, dst_addr;
    logic            hazard;
    logic            rd_wren;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [CW-1:0]   fifo_count;

    wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .main_wren_i (main_wren),
        .main_addr_i (main_addr),
        .main_data_i (main_data),
        .lu_valid_i  (lu_valid),
        .lu_ready_o  (lu_ready),
        .lu_addr_i   (lu_addr),
        .lu_data_i   (lu_data),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .rs1_addr_i  (rs1_addr),
        .rs2_addr_i  (rs2_addr),
        .dst_addr_i  (dst_addr),
        .hazard_o    (hazard),
        .rd_wren_o   (rd_wren),
        .rd_addr_o   (rd_addr),
        .rd_data_o   (rd_data),
        .fifo_count_o(fifo_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: pending long-unit results in acceptance order,
    // and the set of registers with an outstanding result.
    logic [36:0] q[$];
    bit   [31:0] mbusy;

    // Expected values for the current cycle and the model's decisions
    logic            exp_wren;
    logic [4:0]      exp_addr;
    logic [XLEN-1:0] exp_data;
    logic            exp_hazard;
    logic [CW-1:0]   exp_count;
    logic            exp_ready;
    bit              m_pop, m_byp, m_push;

    task automatic idle_inputs();
        main_wren = 0; main_addr = 0; main_data = 0;
        lu_valid  = 0; lu_addr   = 0; lu_data   = 0;
        iss_valid = 0; iss_addr  = 0;
        rs1_addr  = 0; rs2_addr  = 0; dst_addr  = 0;
    endtask

    task automatic model_reset();
        q.delete();
        mbusy = '0;
    endtask

    // Derive this cycle's expected outputs from the model and current inputs.
    task automatic model_eval();
        bit acc;
        exp_ready = (q.size() < DEPTH);
        acc       = lu_valid && exp_ready;
        m_pop = 0; m_byp = 0;
        exp_wren = 0; exp_addr = 0; exp_data = 0;
        if (main_wren && main_addr != 0) begin
            exp_wren = 1; exp_addr = main_addr; exp_data = main_data;
        end else if (q.size() > 0) begin
            exp_wren = 1; exp_addr = q[0][36:32]; exp_data = q[0][31:0];
            m_pop = 1;
        end else if (BYP && acc && lu_addr != 0) begin
            exp_wren = 1; exp_addr = lu_addr; exp_data = lu_data;
            m_byp = 1;
        end
        m_push     = acc && (lu_addr != 0) && !m_byp;
        exp_count  = CW'(q.size());
        exp_hazard = mbusy[rs1_addr] | mbusy[rs2_addr] | mbusy[dst_addr];
    endtask

    // Let combinational outputs settle well after the edge, then evaluate.
    task automatic settle();
        #2;
        model_eval();
    endtask

    // Commit this cycle into the model and advance to just after the edge.
    task automatic tick();
        if (m_pop) begin
            mbusy[exp_addr] = 1'b0;
            void'(q.pop_front());
        end
        if (m_byp) mbusy[lu_addr] = 1'b0;
        if (m_push) q.push_back({lu_addr, lu_data});
        if (iss_valid && iss_addr != 0) mbusy[iss_addr] = 1'b1;
        mbusy[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        idle_inputs();
        main_wren = 1; main_addr = 5'd3; main_data = 32'h1234_5678;
        lu_valid  = 1; lu_addr   = 5'd4; lu_data   = 32'h8765_4321;
        iss_valid = 1; iss_addr  = 5'd5; rs1_addr  = 5'd5;
        repeat (3) @(posedge clk);
        #3;
        $display("reset asserted with main and long-unit traffic");
        n_vec++; if (rd_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren got=%0b exp=0", rd_wren); end
        n_vec++; if (rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", rd_addr); end
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", rd_data); end
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard got=%0b exp=0", hazard); end
        n_vec++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b exp=1", lu_ready); end
        @(posedge clk);
        #1;
        idle_inputs();
        rst_ni = 1;
        model_reset();
        settle();
        // Sweep every register through the query ports: nothing is busy.
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(31 - a); dst_addr = 5'(a);
            #1;
            n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL post_reset_hazard reg=%0d got=%0b exp=0", a, hazard); end
        end
        n_vec++; if (fifo_count !== '0) begin n_err++; $display("FAIL post_reset_count got=%0d exp=0", fifo_count); end
        idle_inputs();
        settle();
        tick();
    endtask

    task automatic test_lu_hazard();
        idle_inputs();
        iss_valid = 1; iss_addr = 5'd5;
        settle(); tick();
        $display("issue x5");
        idle_inputs();
        rs1_addr = 5'd5;
        lu_valid = 1; lu_addr = 5'd5; lu_data = 32'hDEAD_BEEF;
        settle();
        $display("long-unit x5 = %h offered", lu_data);
        n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL lu5_hazard_pending got=%0b exp=1", hazard); end
        n_vec++; if (rd_wren !== exp_wren) begin n_err++; $display("FAIL lu5_accept_wren got=%0b exp=%0b", rd_wren, exp_wren); end
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL lu5_ready got=%0b exp=1", lu_ready); end
        if (BYP) begin
            n_vec++; if (rd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lu5_bypass_data got=%h exp=deadbeef", rd_data); end
        end
        tick();
        lu_valid = 0;
        settle();
        n_vec++; if (rd_wren !== exp_wren || rd_addr !== exp_addr || rd_data !== exp_data) begin
            n_err++; $display("FAIL lu5_write got=%0b/x%0d/%h exp=%0b/x%0d/%h", rd_wren, rd_addr, rd_data, exp_wren, exp_addr, exp_data);
        end
        n_vec++; if (hazard !== exp_hazard) begin n_err++; $display("FAIL lu5_hazard_write_cycle got=%0b exp=%0b", hazard, exp_hazard); end
        tick();
        settle();
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL lu5_hazard_cleared got=%0b exp=0", hazard); end
        tick();
    endtask

    task automatic test_fifo_order();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            main_wren = 1; main_addr = 5'd7; main_data = 32'h700 + 32'(k);
            lu_valid = (k < 2);
            lu_addr  = (k == 0) ? 5'd3 : 5'd4;
            lu_data  = (k == 0) ? 32'h11 : 32'h22;
            settle();
            $display("main x7 = %h, lu_valid=%0b", main_data, lu_valid);
            n_vec++; if (rd_wren !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h700 + 32'(k)) begin
                n_err++; $display("FAIL order_main k=%0d got=%0b/x%0d/%h exp=1/x7/%h", k, rd_wren, rd_addr, rd_data, 32'h700 + 32'(k));
            end
            if (k == 2) begin
                n_vec++; if (fifo_count !== CW'(2)) begin n_err++; $display("FAIL order_count_full got=%0d exp=2", fifo_count); end
                n_vec++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL order_ready_full got=%0b exp=0", lu_ready); end
            end
            tick();
        end
        idle_inputs();
        settle();
        n_vec++; if (rd_wren !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h11) begin
            n_err++; $display("FAIL order_first got=%0b/x%0d/%h exp=1/x3/11", rd_wren, rd_addr, rd_data);
        end
        tick();
        settle();
        n_vec++; if (rd_wren !== 1'b1 || rd_addr !== 5'd4 || rd_data !== 32'h22) begin
            n_err++; $display("FAIL order_second got=%0b/x%0d/%h exp=1/x4/22", rd_wren, rd_addr, rd_data);
        end
        tick();
        settle();
        n_vec++; if (fifo_count !== '0 || rd_wren !== 1'b0) begin
            n_err++; $display("FAIL order_drained count=%0d wren=%0b exp=0/0", fifo_count, rd_wren);
        end
        tick();
    endtask

    task automatic test_full_pop();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            main_wren = 1; main_addr = 5'd7; main_data = 32'h77;
            lu_valid = 1; lu_addr = 5'(10 + k); lu_data = 32'hA0 + 32'(k * 16);
            settle(); tick();
        end
        main_wren = 0;
        lu_valid = 1; lu_addr = 5'd12; lu_data = 32'hC0;
        settle();
        $display("fifo full, main idle, lu x12 offered");
        n_vec++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_pop_cycle got=%0b exp=0", lu_ready); end
        n_vec++; if (rd_addr !== 5'd10 || rd_data !== 32'hA0) begin n_err++; $display("FAIL full_pop_head got=x%0d/%h exp=x10/a0", rd_addr, rd_data); end
        tick();
        settle();
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_next got=%0b exp=1", lu_ready); end
        n_vec++; if (rd_addr !== 5'd11 || rd_data !== 32'hB0) begin n_err++; $display("FAIL full_pop_second got=x%0d/%h exp=x11/b0", rd_addr, rd_data); end
        tick();
        lu_valid = 0;
        settle();
        n_vec++; if (rd_wren !== 1'b1 || rd_addr !== 5'd12 || rd_data !== 32'hC0) begin
            n_err++; $display("FAIL full_pending_written got=%0b/x%0d/%h exp=1/x12/c0", rd_wren, rd_addr, rd_data);
        end
        tick();
    endtask

    task automatic test_set_wins();
        idle_inputs();
        iss_valid = 1; iss_addr = 5'd9;
        settle(); tick();
        idle_inputs();
        main_wren = 1; main_addr = 5'd7; main_data = 32'h7;
        lu_valid = 1; lu_addr = 5'd9; lu_data = 32'h99;
        settle(); tick();
        idle_inputs();
        iss_valid = 1; iss_addr = 5'd9; dst_addr = 5'd9;
        settle();
        $display("x9 retires while x9 is reissued");
        n_vec++; if (rd_wren !== 1'b1 || rd_addr !== 5'd9) begin n_err++; $display("FAIL setwins_write got=%0b/x%0d exp=1/x9", rd_wren, rd_addr); end
        tick();
        iss_valid = 0;
        settle();
        n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL setwins_hazard got=%0b exp=1", hazard); end
        tick();
    endtask

    task automatic test_x0();
        idle_inputs();
        settle();
        // Drain anything left over so the FIFO is empty.
        while (q.size() > 0) begin tick(); settle(); end
        main_wren = 1; main_addr = 5'd0; main_data = 32'h5555;
        lu_valid  = 1; lu_addr   = 5'd0; lu_data   = 32'hAAAA;
        settle();
        $display("main x0 and long-unit x0");
        n_vec++; if (rd_wren !== 1'b0) begin n_err++; $display("FAIL x0_wren got=%0b exp=0", rd_wren); end
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got=%0b exp=1", lu_ready); end
        tick();
        idle_inputs();
        settle();
        n_vec++; if (fifo_count !== '0) begin n_err++; $display("FAIL x0_count got=%0d exp=0", fifo_count); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            main_wren = ($urandom_range(0, 99) < 45);
            main_addr = 5'($urandom_range(0, 7));
            main_data = $urandom;
            lu_valid  = ($urandom_range(0, 99) < 50);
            lu_addr   = 5'($urandom_range(0, 7));
            lu_data   = $urandom;
            iss_valid = ($urandom_range(0, 99) < 30);
            iss_addr  = 5'($urandom_range(0, 7));
            rs1_addr  = 5'($urandom_range(0, 9));
            rs2_addr  = 5'($urandom_range(0, 9));
            dst_addr  = 5'($urandom_range(0, 9));
            settle();
            if (rd_wren) $display("cyc %0d write x%0d = %h", c, rd_addr, rd_data);
            n_vec++; if (rd_wren !== exp_wren) begin n_err++; $display("FAIL rand_wren cyc=%0d got=%0b exp=%0b", c, rd_wren, exp_wren); end
            n_vec++; if (rd_addr !== exp_addr) begin n_err++; $display("FAIL rand_addr cyc=%0d got=%0d exp=%0d", c, rd_addr, exp_addr); end
            n_vec++; if (rd_data !== exp_data) begin n_err++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, rd_data, exp_data); end
            n_vec++; if (hazard !== exp_hazard) begin n_err++; $display("FAIL rand_hazard cyc=%0d got=%0b exp=%0b", c, hazard, exp_hazard); end
            n_vec++; if (fifo_count !== exp_count) begin n_err++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, fifo_count, exp_count); end
            n_vec++; if (lu_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", c, lu_ready, exp_ready); end
            tick();
        end
    endtask

    task automatic test_midreset();
        idle_inputs();
        iss_valid = 1; iss_addr = 5'd6;
        settle(); tick();
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            main_wren = 1; main_addr = 5'd2; main_data = 32'h2;
            lu_valid = 1; lu_addr = 5'd6; lu_data = 32'h66 + 32'(k);
            settle(); tick();
        end
        main_wren = 1; main_addr = 5'd2; main_data = 32'h3;
        lu_valid = 0; rs1_addr = 5'd6;
        settle();
        rst_ni = 0;
        #1;
        $display("reset asserted mid-operation");
        n_vec++; if (rd_wren !== 1'b0) begin n_err++; $display("FAIL midrst_wren got=%0b exp=0", rd_wren); end
        n_vec++; if (fifo_count !== '0) begin n_err++; $display("FAIL midrst_count got=%0d exp=0", fifo_count); end
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL midrst_hazard got=%0b exp=0", hazard); end
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got=%0b exp=1", lu_ready); end
        @(posedge clk);
        #1;
        rst_ni = 1;
        model_reset();
        idle_inputs();
        settle();
        n_vec++; if (rd_wren !== 1'b0 || fifo_count !== '0) begin
            n_err++; $display("FAIL midrst_after wren=%0b count=%0d exp=0/0", rd_wren, fifo_count);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 0;
        model_reset();
        test_reset();
        test_lu_hazard();
        test_fifo_order();
        test_full_pop();
        test_set_wins();
        test_x0();
        test_random();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
